// File: rtl/scm_pkg.sv
// Shared types and elaboration helpers for the latch-based register file.
package scm_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clear_state_e;

    function automatic int unsigned log2_ratio(input int unsigned ratio);
        int unsigned l;
        l = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < ratio) l = i + 1;
        end
        return l;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit widths_ok(input int unsigned wdata_width, input int unsigned rdata_width);
        if (rdata_width == 0 || wdata_width < rdata_width) return 1'b0;
        if ((wdata_width % 8) != 0 || (rdata_width % 8) != 0) return 1'b0;
        if ((wdata_width % rdata_width) != 0) return 1'b0;
        return is_pow2(wdata_width / rdata_width);
    endfunction

endpackage

// File: rtl/register_file_clear_ctrl.sv
// Post-reset zeroing sequencer; muxes its own zero writes with the external write port.
module register_file_clear_ctrl
    import scm_pkg::*;
#(
    parameter int unsigned WADDR_WIDTH    = 5,
    parameter int unsigned WDATA_WIDTH    = 64,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write_enable,
    input  logic [WADDR_WIDTH-1:0]   write_addr,
    input  logic [WDATA_WIDTH-1:0]   write_data,
    input  logic [WDATA_WIDTH/8-1:0] write_be,
    output logic                     mem_we,
    output logic [WADDR_WIDTH-1:0]   mem_waddr,
    output logic [WDATA_WIDTH-1:0]   mem_wdata,
    output logic [WDATA_WIDTH/8-1:0] mem_wbe,
    output logic                     init_busy,
    output logic                     write_ready
);

    clear_state_e           state;
    logic [WADDR_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            if (CLEAR_ON_RESET) begin
                state       <= CLEAR;
                init_busy   <= 1'b1;
                write_ready <= 1'b0;
            end else begin
                state       <= READY;
                init_busy   <= 1'b0;
                write_ready <= 1'b1;
            end
        end else begin
            case (state)
                CLEAR: begin
                    count <= count + 1'b1;
                    if (count == '1) begin
                        state       <= READY;
                        init_busy   <= 1'b0;
                        write_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= READY;
                end
            endcase
        end
    end

    // While clearing, the sequencer owns the write port; external requests are dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = write_addr;
        mem_wdata = write_data;
        mem_wbe   = write_be;
        if (init_busy) begin
            mem_we    = 1'b1;
            mem_waddr = count;
            mem_wdata = '0;
            mem_wbe   = '1;
        end else if (write_enable && write_ready && !rst) begin
            mem_we = 1'b1;
        end
    end

endmodule

// File: rtl/register_file_1w_multi_port_read_be.sv
// Latch-based SCM: one wide byte-enabled write port, N_READ narrow registered-address read ports.
module register_file_1w_multi_port_read_be
    import scm_pkg::*;
#(
    parameter  int unsigned WADDR_WIDTH    = 5,
    parameter  int unsigned WDATA_WIDTH    = 64,
    parameter  int unsigned RDATA_WIDTH    = 32,
    parameter  int unsigned N_READ         = 4,
    parameter  bit          CLEAR_ON_RESET = 1'b1,
    localparam int unsigned RATIO          = WDATA_WIDTH / RDATA_WIDTH,
    localparam int unsigned RADDR_WIDTH    = WADDR_WIDTH + log2_ratio(RATIO)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_READ-1:0]                    ReadEnable,
    input  logic [N_READ-1:0][RADDR_WIDTH-1:0]   ReadAddr,
    output logic [N_READ-1:0][RDATA_WIDTH-1:0]   ReadData,
    output logic [N_READ-1:0]                    ReadValid,
    input  logic                                 WriteEnable,
    output logic                                 WriteReady,
    input  logic [WADDR_WIDTH-1:0]               WriteAddr,
    input  logic [WDATA_WIDTH-1:0]               WriteData,
    input  logic [WDATA_WIDTH/8-1:0]             WriteBe,
    output logic                                 InitBusy
);

    localparam int unsigned NUM_W_WORDS = 2 ** WADDR_WIDTH;
    localparam int unsigned NUM_BYTES   = WDATA_WIDTH / 8;

    if (!widths_ok(WDATA_WIDTH, RDATA_WIDTH)) begin : g_bad_widths
        $error("register_file_1w_multi_port_read_be: illegal WDATA_WIDTH/RDATA_WIDTH");
    end

    logic                                   mem_we;
    logic [WADDR_WIDTH-1:0]                 mem_waddr;
    logic [WDATA_WIDTH-1:0]                 mem_wdata;
    logic [NUM_BYTES-1:0]                   mem_wbe;
    logic [WDATA_WIDTH-1:0]                 wdata_q;
    logic [NUM_W_WORDS-1:0][WDATA_WIDTH-1:0] mem;
    logic [N_READ-1:0][RADDR_WIDTH-1:0]     raddr_q;
    logic [N_READ-1:0]                      rvalid_q;

    register_file_clear_ctrl #(
        .WADDR_WIDTH    (WADDR_WIDTH),
        .WDATA_WIDTH    (WDATA_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_ctrl (
        .clk          (clk),
        .rst          (rst),
        .write_enable (WriteEnable),
        .write_addr   (WriteAddr),
        .write_data   (WriteData),
        .write_be     (WriteBe),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_wbe      (mem_wbe),
        .init_busy    (InitBusy),
        .write_ready  (WriteReady)
    );

    always_ff @(posedge clk) begin
        if (mem_we) wdata_q <= mem_wdata;
    end

    // Each byte lane has its own glitch-free gate (cluster_clock_gating style): the enable is
    // latched while clk is low, so the lane latch is transparent for the high phase after the
    // accepting edge and picks up the freshly registered data.
    for (genvar w = 0; w < NUM_W_WORDS; w++) begin : g_word
        for (genvar b = 0; b < NUM_BYTES; b++) begin : g_lane
            logic       gate_en;
            logic       gate_en_l;
            logic       gclk;
            logic [7:0] lane_q;

            assign gate_en = mem_we && (mem_waddr == WADDR_WIDTH'(w)) && mem_wbe[b];

            always_latch begin
                if (!clk) gate_en_l <= gate_en;
            end

            assign gclk = clk & gate_en_l;

            always_latch begin
                if (gclk) lane_q <= wdata_q[b*8 +: 8];
            end

            assign mem[w][b*8 +: 8] = lane_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raddr_q  <= '0;
            rvalid_q <= '0;
        end else begin
            for (int unsigned p = 0; p < N_READ; p++) begin
                rvalid_q[p] <= ReadEnable[p] && !InitBusy;
                if (ReadEnable[p] && !InitBusy) raddr_q[p] <= ReadAddr[p];
            end
        end
    end

    assign ReadValid = rvalid_q;

    // Upper address bits select the write word, low bits the slice (slice 0 at LSBs).
    for (genvar p = 0; p < N_READ; p++) begin : g_read
        logic [WADDR_WIDTH-1:0] word_idx;
        int unsigned            shift_amt;

        assign word_idx    = raddr_q[p][RADDR_WIDTH-1 -: WADDR_WIDTH];
        assign shift_amt   = 32'(raddr_q[p] & RADDR_WIDTH'(RATIO - 1)) * RDATA_WIDTH;
        assign ReadData[p] = RDATA_WIDTH'(mem[word_idx] >> shift_amt);
    end

endmodule

// File: tb/tb_register_file_1w_multi_port_read_be.sv
// Directed self-checking bench: clear sequence, byte-enabled writes, multi-port reads, no-clear variant.
module tb_register_file_1w_multi_port_read_be;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       read_enable;
    logic [3:0][5:0]  read_addr;
    logic [3:0][31:0] read_data;
    logic [3:0]       read_valid;
    logic             write_enable;
    logic             write_ready;
    logic [4:0]       write_addr;
    logic [63:0]      write_data;
    logic [7:0]       write_be;
    logic             init_busy;

    logic             rst_nc;
    logic [3:0]       read_enable_nc;
    logic [3:0][5:0]  read_addr_nc;
    logic [3:0][31:0] read_data_nc;
    logic [3:0]       read_valid_nc;
    logic             write_enable_nc;
    logic             write_ready_nc;
    logic [4:0]       write_addr_nc;
    logic [63:0]      write_data_nc;
    logic [7:0]       write_be_nc;
    logic             init_busy_nc;

    int unsigned test_count = 0;
    int unsigned fail_count = 0;
    logic        busy_nc_seen = 1'b0;

    always #5 clk = ~clk;

    register_file_1w_multi_port_read_be u_dut (
        .clk         (clk),
        .rst         (rst),
        .ReadEnable  (read_enable),
        .ReadAddr    (read_addr),
        .ReadData    (read_data),
        .ReadValid   (read_valid),
        .WriteEnable (write_enable),
        .WriteReady  (write_ready),
        .WriteAddr   (write_addr),
        .WriteData   (write_data),
        .WriteBe     (write_be),
        .InitBusy    (init_busy)
    );

    register_file_1w_multi_port_read_be #(
        .CLEAR_ON_RESET (1'b0)
    ) u_dut_nc (
        .clk         (clk),
        .rst         (rst_nc),
        .ReadEnable  (read_enable_nc),
        .ReadAddr    (read_addr_nc),
        .ReadData    (read_data_nc),
        .ReadValid   (read_valid_nc),
        .WriteEnable (write_enable_nc),
        .WriteReady  (write_ready_nc),
        .WriteAddr   (write_addr_nc),
        .WriteData   (write_data_nc),
        .WriteBe     (write_be_nc),
        .InitBusy    (init_busy_nc)
    );

    always @(negedge clk) begin
        if (init_busy_nc === 1'b1) busy_nc_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with InitBusy high, starting at the current sample point.
    task automatic count_busy(output int unsigned n, output logic ready_seen, output logic valid_seen);
        n          = 0;
        ready_seen = 1'b0;
        valid_seen = 1'b0;
        while (init_busy && n < 64) begin
            n++;
            if (write_ready) ready_seen = 1'b1;
            if (read_valid != 4'h0) valid_seen = 1'b1;
            tick();
        end
    endtask

    int unsigned n;
    logic        ready_seen;
    logic        valid_seen;

    initial begin
        rst = 1'b1; read_enable = '0; read_addr = '0;
        write_enable = 1'b0; write_addr = '0; write_data = '0; write_be = '0;
        rst_nc = 1'b1; read_enable_nc = '0; read_addr_nc = '0;
        write_enable_nc = 1'b0; write_addr_nc = '0; write_data_nc = '0; write_be_nc = '0;

        // Reset and clear sequence
        tick();
        check("rst_valid", 64'(read_valid), 64'h0);
        check("rst_busy", 64'(init_busy), 64'h1);
        check("nc_busy_after_rst", 64'(init_busy_nc), 64'h0);
        check("nc_ready_after_rst", 64'(write_ready_nc), 64'h1);
        rst = 1'b0;
        rst_nc = 1'b0;
        check("nc_ready_first_cycle", 64'(write_ready_nc), 64'h1);
        count_busy(n, ready_seen, valid_seen);
        check("busy_cycles", 64'(n), 64'd32);
        check("ready_low_while_busy", 64'(ready_seen), 64'h0);
        check("ready_after_clear", 64'(write_ready), 64'h1);

        // All 64 read addresses return zero, one cycle latency
        for (int c = 0; c < 16; c++) begin
            read_enable = 4'hF;
            for (int p = 0; p < 4; p++) read_addr[p] = 6'(c * 4 + p);
            tick();
            check("clr_valid", 64'(read_valid), 64'hF);
            for (int p = 0; p < 4; p++) check("clr_data", 64'(read_data[p]), 64'h0);
        end
        read_enable = '0;
        tick();
        check("valid_drop", 64'(read_valid), 64'h0);

        // Full-word write then split reads
        write_enable = 1'b1; write_addr = 5'd3; write_data = 64'h1122334455667788; write_be = 8'hFF;
        tick();
        write_enable = 1'b0;
        read_enable = 4'b0011; read_addr[0] = 6'd6; read_addr[1] = 6'd7;
        tick();
        check("full_lo", 64'(read_data[0]), 64'h55667788);
        check("full_hi", 64'(read_data[1]), 64'h11223344);
        check("full_valid", 64'(read_valid), 64'h3);

        // Lower-half byte-enable write keeps upper half
        read_enable = '0;
        write_enable = 1'b1; write_data = 64'hAAAAAAAAAAAAAAAA; write_be = 8'h0F;
        tick();
        write_enable = 1'b0;
        read_enable = 4'b0011;
        tick();
        check("be_lo", 64'(read_data[0]), 64'hAAAAAAAA);
        check("be_hi", 64'(read_data[1]), 64'h11223344);

        // Same-edge write and four-port read of the written slice
        write_enable = 1'b1; write_data = 64'hDEADBEEF00000000; write_be = 8'hF0;
        read_enable = 4'hF;
        for (int p = 0; p < 4; p++) read_addr[p] = 6'd7;
        tick();
        write_enable = 1'b0;
        read_enable = '0;
        check("raw_valid", 64'(read_valid), 64'hF);
        for (int p = 0; p < 4; p++) check("raw_data", 64'(read_data[p]), 64'hDEADBEEF);
        tick();
        check("hold_valid", 64'(read_valid), 64'h0);
        check("hold_data", 64'(read_data[3]), 64'hDEADBEEF);

        // Held address tracks later writes
        write_enable = 1'b1; write_data = 64'h0123456700000000; write_be = 8'hF0;
        tick();
        write_enable = 1'b0;
        check("track_data", 64'(read_data[2]), 64'h01234567);

        // Reset mid-clear restarts the counter; writes and reads while busy are dropped
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_clear_busy", 64'(init_busy), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        write_enable = 1'b1; write_addr = 5'd2; write_data = 64'hFFFFFFFFFFFFFFFF; write_be = 8'hFF;
        read_enable = 4'hF;
        for (int p = 0; p < 4; p++) read_addr[p] = 6'd5;
        count_busy(n, ready_seen, valid_seen);
        write_enable = 1'b0;
        read_enable = '0;
        check("restart_busy_cycles", 64'(n), 64'd32);
        check("restart_ready_low", 64'(ready_seen), 64'h0);
        check("restart_no_valid", 64'(valid_seen), 64'h0);
        check("restart_addr_held", 64'(read_addr[0] == 6'd5 && read_valid == 4'h0), 64'h1);
        read_enable = 4'hF;
        read_addr[0] = 6'd4; read_addr[1] = 6'd5; read_addr[2] = 6'd6; read_addr[3] = 6'd7;
        tick();
        read_enable = '0;
        check("restart_valid", 64'(read_valid), 64'hF);
        check("drop_w2_lo", 64'(read_data[0]), 64'h0);
        check("drop_w2_hi", 64'(read_data[1]), 64'h0);
        check("recleared_w3_lo", 64'(read_data[2]), 64'h0);
        check("recleared_w3_hi", 64'(read_data[3]), 64'h0);

        // No-clear instance: write then read back
        write_enable_nc = 1'b1; write_addr_nc = 5'd9; write_data_nc = 64'hCAFEF00D12345678; write_be_nc = 8'hFF;
        tick();
        write_enable_nc = 1'b0;
        read_enable_nc = 4'b0011; read_addr_nc[0] = 6'd18; read_addr_nc[1] = 6'd19;
        tick();
        read_enable_nc = '0;
        check("nc_valid", 64'(read_valid_nc), 64'h3);
        check("nc_lo", 64'(read_data_nc[0]), 64'h12345678);
        check("nc_hi", 64'(read_data_nc[1]), 64'hCAFEF00D);
        check("nc_never_busy", 64'(busy_nc_seen), 64'h0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/register_file_1w_multi_port_read_be.md
Name: register_file_1w_multi_port_read_be

Overview:
Latch-based standard-cell memory (SCM) with one wide write port and N_READ narrow read ports.
- Width ratio WDATA_WIDTH/RDATA_WIDTH is any power of two.
- Writes support per-byte enables, so partial-word writes need no read-modify-write.
- An optional post-reset clear sequencer zeroes every word before the first write is accepted.
- Used as a multi-ported operand/TCDM-side buffer in the cluster, wherever a 64b refill path feeds 32b consumers.

Parameters:
WADDR_WIDTH, 5, write-word address width; NUM_W_WORDS = 2**WADDR_WIDTH.
WDATA_WIDTH, 64, write word width; multiple of 8.
RDATA_WIDTH, 32, read word width; multiple of 8; WDATA_WIDTH/RDATA_WIDTH is a power of two ≥1.
RATIO, WDATA_WIDTH/RDATA_WIDTH, derived.
RADDR_WIDTH, WADDR_WIDTH+$clog2(RATIO), derived; NUM_R_WORDS = 2**RADDR_WIDTH.
N_READ, 4, number of read ports.
CLEAR_ON_RESET, 1, 1 = run the zeroing sequence after reset; 0 = skip it.

Ports:
clk  in  1  single clock, all state on rising edge.
rst  in  1  synchronous, active-high reset.
ReadEnable  in  N_READ  per-port read request; captures ReadAddr.
ReadAddr  in  N_READ x RADDR_WIDTH  read-word address.
ReadData  out  N_READ x RDATA_WIDTH  read data.
ReadValid  out  N_READ  high the cycle after an accepted read.
WriteEnable  in  1  write request.
WriteReady  out  1  write can be accepted this cycle.
WriteAddr  in  WADDR_WIDTH  write-word address.
WriteData  in  WDATA_WIDTH  write data.
WriteBe  in  WDATA_WIDTH/8  byte enables; bit b covers WriteData[8b+7:8b].
InitBusy  out  1  clear sequence in progress.

Behaviour:
Interface: one clock, clk; reset rst is synchronous and active-high.

Reset (rst high at a posedge):
- ReadValid=0, read-address registers=0.
- Clear FSM enters CLEAR with counter=0 if CLEAR_ON_RESET, otherwise READY.
- Memory contents are undefined unless cleared.

FSM states and outputs:
- CLEAR: InitBusy=1, WriteReady=0. Each cycle writes zero to word counter, with all byte enables set. Counter increments; the transition to READY happens after word NUM_W_WORDS-1. InitBusy is therefore high for exactly NUM_W_WORDS cycles after rst deasserts.
- READY: InitBusy=0, WriteReady=1. The state is held until rst.
- rst asserted mid-CLEAR restarts the counter at 0.

During InitBusy:
- External WriteEnable is dropped, with no side effect.
- ReadEnable is ignored: ReadValid stays 0 and the address registers hold.

Write path:
- Accepted when WriteEnable && WriteReady at posedge E.
- Data, address and byte enables are registered at E.
- Per-word, per-byte-lane clock gates (cluster_clock_gating) open the matching latch bytes during the high phase following E.
- Lanes with WriteBe[b]=0 keep their old content.
- WriteBe=0 with WriteEnable=1 is accepted as a no-op.

Read path:
- ReadEnable[p] at posedge E registers ReadAddr[p]. ReadValid[p] is 1 during cycle E..E+1 and 0 otherwise.
- ReadData[p] is a combinational mux from the latch array on the registered address: write word = addr>>log2(RATIO), slice = addr mod RATIO, slice 0 at LSBs.
- When ReadEnable is low the address holds, and ReadData tracks the current content at that address.
- Read-after-write: a write accepted at E is visible to any read whose address is registered at E or later. A read and a write to the same word at the same edge return the new data.
- All ports may hit the same address simultaneously.
- No port arbitration; latency is fixed at 1 cycle.

Decomposition:
Shared package scm_pkg holds:
- clear FSM enum (CLEAR, READY);
- a function computing log2(RATIO);
- elaboration-time checks that RATIO is a power of two and the widths are byte multiples.

Sub-module register_file_clear_ctrl contains the FSM plus counter. It outputs the muxed internal write request (en, addr, be, data) and InitBusy/WriteReady. The top level contains the gates, latches and read muxes.

Test Plan:
1. Default params, rst 1 cycle -> InitBusy high exactly 32 cycles, WriteReady=0 throughout; then read all 64 addresses -> every ReadData=0x00000000, ReadValid one cycle after each ReadEnable.
2. Write addr 3, data 0x1122334455667788, be 0xFF; next cycle port0 reads 6, port1 reads 7 -> 0x55667788 and 0x11223344.
3. Then write addr 3, data 0xAAAAAAAAAAAAAAAA, be 0x0F -> read 6 = 0xAAAAAAAA, read 7 = 0x11223344 (unchanged).
4. All 4 ports ReadEnable addr 7 at the same edge as a write to addr 3 with data 0xDEADBEEF00000000, be 0xF0 -> all ports show 0xDEADBEEF in the following cycle.
5. Assert rst when the clear counter is 10, and drive WriteEnable during busy -> counter restarts at 0, InitBusy high 32 cycles after deassertion, and the dropped writes leave the contents 0.
6. CLEAR_ON_RESET=0 -> InitBusy never rises, WriteReady=1 the first cycle after rst; write then read returns the written data.
